agc_controller: RTL and testbench

AGC_CONTROLLER -- requirements
Module: agc_controller

---
 rtl/agc_controller.sv | 152 +++++++++++++++
 tb/tb_agc_controller.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_controller.sv
// Automatic gain control loop. Envelope samples are classified against a
// target window: a high sample steps the gain down at once, and a long run
// of low samples steps it up. Every gain change is followed by a hold
// period, so the loop does not react to its own transient.
module agc_controller #(
  parameter int GAIN_INIT     = 8,
  parameter int GAIN_MAX      = 15,
  parameter int HYST          = 8,
  parameter int HOLD_SAMPLES  = 64,
  parameter int DECAY_SAMPLES = 256
) (
  input  logic       clk,
  input  logic       RSTb,
  input  logic       enable,
  input  logic [7:0] env_in,
  input  logic       env_valid,
  input  logic [7:0] target,
  output logic [3:0] gain,
  output logic       gain_update,
  output logic [2:0] agc_state
);

  // The counters are sized to hold the full parameter value, so they never wrap.
  localparam int LOW_W  = (DECAY_SAMPLES > 0) ? $clog2(DECAY_SAMPLES + 1) : 1;
  localparam int HOLD_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;

  localparam logic [LOW_W-1:0]  LOW_LAST  = LOW_W'(DECAY_SAMPLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES);
  localparam logic [3:0]        GAIN_RST  = 4'(GAIN_INIT);
  localparam logic [3:0]        GAIN_TOP  = 4'(GAIN_MAX);
  localparam logic [8:0]        HYST9     = 9'(HYST);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRACK  = 3'd1,
    ATTACK = 3'd2,
    DECAY  = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [LOW_W-1:0]  low_cnt, low_cnt_next, low_inc;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic [3:0]        gain_next;
  logic              gain_update_next;

  logic [8:0] magnitude, target9, thr_hi, thr_lo;
  logic       is_high, is_low;

  // Negative envelopes count as zero. Thresholds are kept in 9 bits so that
  // target + HYST cannot overflow, and the low threshold floors at zero.
  assign magnitude = env_in[7] ? 9'd0 : {2'b00, env_in[6:0]};
  assign target9   = {1'b0, target};
  assign thr_hi    = target9 + HYST9;
  assign thr_lo    = (HYST9 > target9) ? 9'd0 : (target9 - HYST9);
  assign is_high   = (magnitude > thr_hi);
  assign is_low    = (magnitude < thr_lo);
  assign low_inc   = low_cnt + 1'b1;

  assign agc_state = state;

  // Next-state and next-output logic. Dropping enable overrides every state.
  always_comb begin
    state_next       = state;
    low_cnt_next     = low_cnt;
    hold_cnt_next    = hold_cnt;
    gain_next        = gain;
    gain_update_next = 1'b0;

    if (!enable) begin
      state_next    = IDLE;
      low_cnt_next  = '0;
      hold_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next    = TRACK;
          low_cnt_next  = '0;
          hold_cnt_next = '0;
        end
        TRACK: begin
          if (env_valid) begin
            if (is_high) begin
              state_next   = ATTACK;
              low_cnt_next = '0;
            end else if (is_low) begin
              if (low_inc >= LOW_LAST) begin
                state_next   = DECAY;
                low_cnt_next = '0;
              end else begin
                low_cnt_next = low_inc;
              end
            end else begin
              low_cnt_next = '0;
            end
          end
        end
        ATTACK: begin
          // Any strobe arriving in this cycle is ignored.
          if (gain != 4'd0) begin
            gain_next        = gain - 1'b1;
            gain_update_next = 1'b1;
          end
          state_next    = HOLD;
          hold_cnt_next = HOLD_LOAD;
        end
        DECAY: begin
          if (gain < GAIN_TOP) begin
            gain_next        = gain + 1'b1;
            gain_update_next = 1'b1;
          end
          state_next    = HOLD;
          hold_cnt_next = HOLD_LOAD;
        end
        HOLD: begin
          // Strobes only count down here; their level is not evaluated.
          if (hold_cnt == '0) begin
            state_next = TRACK;
          end else if (env_valid) begin
            hold_cnt_next = hold_cnt - 1'b1;
            if (hold_cnt == HOLD_W'(1)) begin
              state_next = TRACK;
            end
          end
        end
        default: begin
          state_next    = IDLE;
          low_cnt_next  = '0;
          hold_cnt_next = '0;
        end
      endcase
    end
  end

  // State, counters and the registered gain outputs.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      state       <= IDLE;
      low_cnt     <= '0;
      hold_cnt    <= '0;
      gain        <= GAIN_RST;
      gain_update <= 1'b0;
    end else begin
      state       <= state_next;
      low_cnt     <= low_cnt_next;
      hold_cnt    <= hold_cnt_next;
      gain        <= gain_next;
      gain_update <= gain_update_next;
    end
  end

endmodule

// File: tb/tb_agc_controller.sv
// Self-checking bench for agc_controller (default parameters).
// Every expected gain change is queued when its stimulus is driven. A monitor
// pops the queue on each gain_update pulse, and an empty queue means the pulse
// was not expected.
`timescale 1ns/1ps
module tb_agc_controller;

  logic       clk;
  logic       RSTb;
  logic       enable;
  logic [7:0] env_in;
  logic       env_valid;
  logic [7:0] target;
  logic [3:0] gain;
  logic       gain_update;
  logic [2:0] agc_state;

  int vectors     = 0;
  int miscompares = 0;
  int exp_gain_q[$];
  int mon_exp;

  agc_controller dut (
    .clk         (clk),
    .RSTb        (RSTb),
    .enable      (enable),
    .env_in      (env_in),
    .env_valid   (env_valid),
    .target      (target),
    .gain        (gain),
    .gain_update (gain_update),
    .agc_state   (agc_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every gain_update pulse must match a queued gain.
  always @(negedge clk) begin
    if (RSTb === 1'b1 && gain_update !== 1'b0) begin
      vectors++;
      if (exp_gain_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_update: gain_update=%b gain=%0d, required no pulse", gain_update, gain);
      end else begin
        mon_exp = exp_gain_q.pop_front();
        if (gain !== 4'(mon_exp)) begin
          miscompares++;
          $display("FAIL update_gain: gain=%0d required %0d", gain, mon_exp);
        end
      end
    end
  end

  // Watchdog: ends the run if a test overruns its budget.
  initial begin
    #2ms;
    miscompares++;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  // One strobe, then one idle cycle. Called and returns 1 ns after a rising edge.
  task automatic strobe(input logic [7:0] v);
    env_in    = v;
    env_valid = 1'b1;
    @(posedge clk); #1;
    env_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Sixty-four in-band strobes (target 64) run out the hold period.
  task automatic exit_hold();
    repeat (64) strobe(8'd64);
  endtask

  // Reset pulse with enable high; the loop is in TRACK on return, gain = 8.
  task automatic restart();
    #1;
    RSTb = 1'b0;
    @(posedge clk); #1;
    RSTb   = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    RSTb = 1'b1; enable = 1'b0; env_valid = 1'b0; env_in = 8'd0; target = 8'd64;
    #2;
    RSTb = 1'b0;
    #1;
    vectors++;
    if (gain !== 4'd8) begin miscompares++; $display("FAIL reset_gain: gain=%0d required 8", gain); end
    vectors++;
    if (gain_update !== 1'b0) begin miscompares++; $display("FAIL reset_update: gain_update=%b required 0", gain_update); end
    vectors++;
    if (agc_state !== 3'd0) begin miscompares++; $display("FAIL reset_state: agc_state=%0d required 0", agc_state); end
    repeat (2) @(posedge clk); #1;
    RSTb = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (agc_state !== 3'd0) begin miscompares++; $display("FAIL idle_disabled: agc_state=%0d required 0", agc_state); end
    enable = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (agc_state !== 3'd1) begin miscompares++; $display("FAIL idle_to_track: agc_state=%0d required 1", agc_state); end
    $display("test_reset done");
  endtask

  task automatic test_attack();
    env_in = 8'd100; env_valid = 1'b1;
    exp_gain_q.push_back(7);
    @(negedge clk);
    vectors++;
    if (agc_state !== 3'd1) begin miscompares++; $display("FAIL attack_pre: agc_state=%0d required 1", agc_state); end
    @(posedge clk); #1;
    env_valid = 1'b0;
    vectors++;
    if (agc_state !== 3'd2 || gain !== 4'd8 || gain_update !== 1'b0) begin
      miscompares++; $display("FAIL attack_state: state=%0d gain=%0d upd=%b required 2/8/0", agc_state, gain, gain_update);
    end
    @(posedge clk); #1;
    vectors++;
    if (agc_state !== 3'd4 || gain !== 4'd7 || gain_update !== 1'b1) begin
      miscompares++; $display("FAIL attack_hold: state=%0d gain=%0d upd=%b required 4/7/1", agc_state, gain, gain_update);
    end
    @(posedge clk); #1;
    vectors++;
    if (gain_update !== 1'b0) begin miscompares++; $display("FAIL attack_pulse_len: gain_update=%b required 0", gain_update); end
    exit_hold();
    vectors++;
    if (agc_state !== 3'd1) begin miscompares++; $display("FAIL attack_exit: agc_state=%0d required 1", agc_state); end
    $display("test_attack done");
  endtask

  task automatic test_decay();
    restart();
    repeat (255) strobe(8'd20);
    vectors++;
    if (gain !== 4'd8 || agc_state !== 3'd1) begin
      miscompares++; $display("FAIL decay_early: gain=%0d state=%0d required 8/1", gain, agc_state);
    end
    exp_gain_q.push_back(9);
    strobe(8'd20);
    vectors++;
    if (gain !== 4'd9 || agc_state !== 3'd4) begin
      miscompares++; $display("FAIL decay_step: gain=%0d state=%0d required 9/4", gain, agc_state);
    end
    exit_hold();
    // An in-band sample at strobe 200 restarts the run of low samples.
    repeat (199) strobe(8'd20);
    strobe(8'd60);
    repeat (255) strobe(8'd20);
    vectors++;
    if (gain !== 4'd9 || agc_state !== 3'd1) begin
      miscompares++; $display("FAIL decay_inband_reset: gain=%0d state=%0d required 9/1", gain, agc_state);
    end
    exp_gain_q.push_back(10);
    strobe(8'd20);
    vectors++;
    if (gain !== 4'd10 || agc_state !== 3'd4) begin
      miscompares++; $display("FAIL decay_second: gain=%0d state=%0d required 10/4", gain, agc_state);
    end
    exit_hold();
    $display("test_decay done");
  endtask

  task automatic test_thresholds();
    strobe(8'd72);
    strobe(8'd56);
    vectors++;
    if (agc_state !== 3'd1 || gain !== 4'd10) begin
      miscompares++; $display("FAIL band_edges: state=%0d gain=%0d required 1/10", agc_state, gain);
    end
    exp_gain_q.push_back(9);
    strobe(8'd73);
    vectors++;
    if (agc_state !== 3'd4 || gain !== 4'd9) begin
      miscompares++; $display("FAIL above_hi: state=%0d gain=%0d required 4/9", agc_state, gain);
    end
    exit_hold();
    exp_gain_q.push_back(10);
    repeat (256) strobe(8'd55);
    vectors++;
    if (agc_state !== 3'd4 || gain !== 4'd10) begin
      miscompares++; $display("FAIL below_lo: state=%0d gain=%0d required 4/10", agc_state, gain);
    end
    exit_hold();
    // target 8: lo = 0, so a negative sample (magnitude 0) is in-band.
    target = 8'd8;
    repeat (256) strobe(8'h9C);
    vectors++;
    if (agc_state !== 3'd1 || gain !== 4'd10) begin
      miscompares++; $display("FAIL negative_inband: state=%0d gain=%0d required 1/10", agc_state, gain);
    end
    // target 4: lo clamps to 0 rather than wrapping.
    target = 8'd4;
    repeat (256) strobe(8'd0);
    vectors++;
    if (agc_state !== 3'd1 || gain !== 4'd10) begin
      miscompares++; $display("FAIL lo_clamp: state=%0d gain=%0d required 1/10", agc_state, gain);
    end
    // target 64: a negative sample is low.
    target = 8'd64;
    exp_gain_q.push_back(11);
    repeat (256) strobe(8'h9C);
    vectors++;
    if (agc_state !== 3'd4 || gain !== 4'd11) begin
      miscompares++; $display("FAIL negative_low: state=%0d gain=%0d required 4/11", agc_state, gain);
    end
    exit_hold();
    $display("test_thresholds done");
  endtask

  task automatic test_enable();
    env_in = 8'd100; env_valid = 1'b1;
    @(posedge clk); #1;
    env_valid = 1'b0;
    vectors++;
    if (agc_state !== 3'd2) begin miscompares++; $display("FAIL enable_attack: agc_state=%0d required 2", agc_state); end
    enable = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (agc_state !== 3'd0 || gain !== 4'd11 || gain_update !== 1'b0) begin
      miscompares++; $display("FAIL enable_abandon: state=%0d gain=%0d upd=%b required 0/11/0", agc_state, gain, gain_update);
    end
    enable = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (agc_state !== 3'd1) begin miscompares++; $display("FAIL enable_resume: agc_state=%0d required 1", agc_state); end
    // Dropping enable clears the partial run of low samples.
    repeat (200) strobe(8'd20);
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    repeat (100) strobe(8'd20);
    vectors++;
    if (agc_state !== 3'd1 || gain !== 4'd11) begin
      miscompares++; $display("FAIL enable_clears_low: state=%0d gain=%0d required 1/11", agc_state, gain);
    end
    strobe(8'd64);
    $display("test_enable done");
  endtask

  task automatic test_hold();
    exp_gain_q.push_back(10);
    strobe(8'd100);
    repeat (63) strobe(8'd100);
    vectors++;
    if (agc_state !== 3'd4 || gain !== 4'd10) begin
      miscompares++; $display("FAIL hold_63: state=%0d gain=%0d required 4/10", agc_state, gain);
    end
    strobe(8'd100);
    vectors++;
    if (agc_state !== 3'd1 || gain !== 4'd10) begin
      miscompares++; $display("FAIL hold_64: state=%0d gain=%0d required 1/10", agc_state, gain);
    end
    exp_gain_q.push_back(9);
    strobe(8'd100);
    vectors++;
    if (agc_state !== 3'd4 || gain !== 4'd9) begin
      miscompares++; $display("FAIL hold_retrigger: state=%0d gain=%0d required 4/9", agc_state, gain);
    end
    exit_hold();
    $display("test_hold done");
  endtask

  task automatic test_back_to_back();
    // A strobe on every cycle: the one landing in ATTACK is dropped, and the
    // next 64 count down the hold.
    exp_gain_q.push_back(8);
    env_in = 8'd100; env_valid = 1'b1;
    repeat (65) @(posedge clk);
    #1;
    vectors++;
    if (agc_state !== 3'd4 || gain !== 4'd8) begin
      miscompares++; $display("FAIL b2b_hold: state=%0d gain=%0d required 4/8", agc_state, gain);
    end
    @(posedge clk); #1;
    env_valid = 1'b0;
    vectors++;
    if (agc_state !== 3'd1 || gain !== 4'd8) begin
      miscompares++; $display("FAIL b2b_exit: state=%0d gain=%0d required 1/8", agc_state, gain);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_saturation();
    restart();
    for (int k = 1; k <= 8; k++) begin
      exp_gain_q.push_back(8 - k);
      strobe(8'd100);
      exit_hold();
    end
    env_in = 8'd100; env_valid = 1'b1;
    @(posedge clk); #1;
    env_valid = 1'b0;
    vectors++;
    if (agc_state !== 3'd2) begin miscompares++; $display("FAIL sat_low_attack: agc_state=%0d required 2", agc_state); end
    @(posedge clk); #1;
    vectors++;
    if (agc_state !== 3'd4 || gain !== 4'd0 || gain_update !== 1'b0) begin
      miscompares++; $display("FAIL sat_low: state=%0d gain=%0d upd=%b required 4/0/0", agc_state, gain, gain_update);
    end
    exit_hold();
    restart();
    for (int k = 9; k <= 15; k++) begin
      exp_gain_q.push_back(k);
      repeat (256) strobe(8'd20);
      exit_hold();
    end
    repeat (255) strobe(8'd20);
    env_in = 8'd20; env_valid = 1'b1;
    @(posedge clk); #1;
    env_valid = 1'b0;
    vectors++;
    if (agc_state !== 3'd3) begin miscompares++; $display("FAIL sat_high_decay: agc_state=%0d required 3", agc_state); end
    @(posedge clk); #1;
    vectors++;
    if (agc_state !== 3'd4 || gain !== 4'd15 || gain_update !== 1'b0) begin
      miscompares++; $display("FAIL sat_high: state=%0d gain=%0d upd=%b required 4/15/0", agc_state, gain, gain_update);
    end
    exit_hold();
    $display("test_saturation done");
  endtask

  task automatic test_reset_mid();
    // Reset taken in the ATTACK cycle.
    env_in = 8'd100; env_valid = 1'b1;
    @(posedge clk); #1;
    env_valid = 1'b0;
    vectors++;
    if (agc_state !== 3'd2) begin miscompares++; $display("FAIL rst_attack_pre: agc_state=%0d required 2", agc_state); end
    #1;
    RSTb = 1'b0;
    #1;
    vectors++;
    if (gain !== 4'd8 || agc_state !== 3'd0 || gain_update !== 1'b0) begin
      miscompares++; $display("FAIL rst_attack_async: gain=%0d state=%0d upd=%b required 8/0/0", gain, agc_state, gain_update);
    end
    @(posedge clk); #1;
    vectors++;
    if (gain !== 4'd8) begin miscompares++; $display("FAIL rst_attack_gain: gain=%0d required 8", gain); end
    RSTb = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (agc_state !== 3'd1) begin miscompares++; $display("FAIL rst_first_edge: agc_state=%0d required 1", agc_state); end
    // Reset taken part-way through HOLD.
    exp_gain_q.push_back(7);
    strobe(8'd100);
    repeat (10) strobe(8'd64);
    vectors++;
    if (agc_state !== 3'd4 || gain !== 4'd7) begin
      miscompares++; $display("FAIL rst_hold_pre: state=%0d gain=%0d required 4/7", agc_state, gain);
    end
    #2;
    RSTb = 1'b0;
    #1;
    vectors++;
    if (gain !== 4'd8 || agc_state !== 3'd0) begin
      miscompares++; $display("FAIL rst_hold_async: gain=%0d state=%0d required 8/0", gain, agc_state);
    end
    @(posedge clk); #1;
    RSTb = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (agc_state !== 3'd1 || gain !== 4'd8) begin
      miscompares++; $display("FAIL rst_hold_resume: state=%0d gain=%0d required 1/8", agc_state, gain);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_attack();
    test_decay();
    test_thresholds();
    test_enable();
    test_hold();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    repeat (2) @(posedge clk);
    vectors++;
    if (exp_gain_q.size() != 0) begin
      miscompares++; $display("FAIL pending_updates: %0d queued gain changes never seen, required 0", exp_gain_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
